// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU pixel pipeline front end:
// scheduler state encoding and default screen / layer constants.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  localparam int DEF_HOR_PIX    = 480;
  localparam int DEF_VER_PIX    = 272;
  localparam int DEF_NUM_LAYERS = 32;

endpackage

// File: rtl/layer_next_finder.sv
// Combinational layer search for layer_scheduler: lowest enabled layer,
// lowest enabled layer strictly above the current one, and mask summaries.
// Only present when LAYER_SCHED_SKIP_EN is defined; the default build
// steps through every layer without it.
`ifdef LAYER_SCHED_SKIP_EN
module layer_next_finder #(
  parameter int NUM_LAYERS  = 4,
  parameter int LAYER_DEPTH = 2
) (
  input  logic [NUM_LAYERS-1:0]  i_mask,
  input  logic [LAYER_DEPTH-1:0] i_cur,
  output logic [LAYER_DEPTH-1:0] o_first,
  output logic [LAYER_DEPTH-1:0] o_next,
  output logic                   o_hasNext,
  output logic                   o_anyEn
);

  // Priority encoders; scanning downwards lets the lowest hit win.
  always_comb begin
    o_first   = '0;
    o_next    = '0;
    o_hasNext = 1'b0;
    o_anyEn   = |i_mask;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_first = LAYER_DEPTH'(i);
      end
      if (i_mask[i] && (i > int'(i_cur))) begin
        o_next    = LAYER_DEPTH'(i);
        o_hasNext = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/layer_scheduler.sv
// Frame-level raster scheduler: walks y, x, layer and emits one token per
// live layer per pixel over valid/ready, with a one-cycle frameDone pulse.
// LAYER_SCHED_SKIP_EN: when defined, layers disabled in the latched mask are
// skipped; otherwise every layer is emitted and layerEn is ignored.
module layer_scheduler
  import gpu_pkg::*;
#(
  parameter int HOR_PIX     = DEF_HOR_PIX,
  parameter int VER_PIX     = DEF_VER_PIX,
  parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
  parameter int X_DEPTH     = $clog2(HOR_PIX),
  parameter int Y_DEPTH     = $clog2(VER_PIX),
  parameter int LAYER_DEPTH = $clog2(NUM_LAYERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_LAYERS-1:0]  layerEn,
  input  logic                   ready,
  output logic                   valid,
  output logic [LAYER_DEPTH-1:0] layer,
  output logic [X_DEPTH-1:0]     x,
  output logic [Y_DEPTH-1:0]     y,
  output logic                   empty,
  output logic                   lastLayer,
  output logic                   lastPixel,
  output logic                   busy,
  output logic                   frameDone
);

  sched_state_e           r_state, w_state_n;
  logic [NUM_LAYERS-1:0]  r_maskQ, w_maskQ_n;
  logic [LAYER_DEPTH-1:0] r_layer, w_layer_n;
  logic [X_DEPTH-1:0]     r_x, w_x_n;
  logic [Y_DEPTH-1:0]     r_y, w_y_n;
  logic                   r_valid, w_valid_n;
  logic                   r_empty, w_empty_n;
  logic                   r_lastLayer, w_lastLayer_n;
  logic                   r_lastPixel, w_lastPixel_n;
  logic                   r_frameDone, w_frameDone_n;

  logic [NUM_LAYERS-1:0]  w_mask;
  logic [LAYER_DEPTH-1:0] w_first, w_next;
  logic                   w_hasNext, w_anyEn;

  // True when no enabled layer lies above idx, i.e. idx closes the pixel.
  function automatic logic f_none_above(input logic [NUM_LAYERS-1:0]  mask,
                                        input logic [LAYER_DEPTH-1:0] idx);
    logic res;
    res = 1'b1;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (mask[i] && (i > int'(idx))) res = 1'b0;
    end
    return res;
  endfunction

`ifdef LAYER_SCHED_SKIP_EN
  // During LOAD the mask register is not yet written, so search layerEn.
  assign w_mask = (r_state == LOAD) ? layerEn : r_maskQ;

  layer_next_finder #(
    .NUM_LAYERS  (NUM_LAYERS),
    .LAYER_DEPTH (LAYER_DEPTH)
  ) u_finder (
    .i_mask    (w_mask),
    .i_cur     (r_layer),
    .o_first   (w_first),
    .o_next    (w_next),
    .o_hasNext (w_hasNext),
    .o_anyEn   (w_anyEn)
  );
`else
  // Every layer is live: plain wrap-around counter over 0..NUM_LAYERS-1.
  assign w_mask    = '1;
  assign w_first   = '0;
  assign w_next    = r_layer + 1'b1;
  assign w_hasNext = (r_layer != LAYER_DEPTH'(NUM_LAYERS - 1));
  assign w_anyEn   = 1'b1;
  wire   w_unused_mask = ^{layerEn, r_maskQ};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  // Next-state and next-token computation; token flags derive from the next
  // position so all outputs leave the registers below.
  always_comb begin
    w_state_n     = r_state;
    w_maskQ_n     = r_maskQ;
    w_layer_n     = r_layer;
    w_x_n         = r_x;
    w_y_n         = r_y;
    w_valid_n     = r_valid;
    w_frameDone_n = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_n = LOAD;
      end
      LOAD: begin
        w_state_n = RUN;
        w_maskQ_n = layerEn;
        w_valid_n = 1'b1;
        w_layer_n = w_first;
        w_x_n     = '0;
        w_y_n     = '0;
      end
      RUN: begin
        if (ready) begin
          if (r_lastPixel) begin
            w_state_n     = DONE;
            w_valid_n     = 1'b0;
            w_frameDone_n = 1'b1;
          end else if (w_hasNext) begin
            w_layer_n = w_next;
          end else begin
            w_layer_n = w_first;
            if (r_x == X_DEPTH'(HOR_PIX - 1)) begin
              w_x_n = '0;
              w_y_n = r_y + 1'b1;
            end else begin
              w_x_n = r_x + 1'b1;
            end
          end
        end
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    w_empty_n     = w_valid_n && !w_anyEn;
    w_lastLayer_n = w_valid_n && f_none_above(w_mask, w_layer_n);
    w_lastPixel_n = w_lastLayer_n && (w_x_n == X_DEPTH'(HOR_PIX - 1))
                    && (w_y_n == Y_DEPTH'(VER_PIX - 1));
  end

  // Registered token, mask and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_maskQ     <= '0;
      r_layer     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_valid     <= 1'b0;
      r_empty     <= 1'b0;
      r_lastLayer <= 1'b0;
      r_lastPixel <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_maskQ     <= w_maskQ_n;
      r_layer     <= w_layer_n;
      r_x         <= w_x_n;
      r_y         <= w_y_n;
      r_valid     <= w_valid_n;
      r_empty     <= w_empty_n;
      r_lastLayer <= w_lastLayer_n;
      r_lastPixel <= w_lastPixel_n;
      r_frameDone <= w_frameDone_n;
    end
  end

  assign valid     = r_valid;
  assign layer     = r_layer;
  assign x         = r_x;
  assign y         = r_y;
  assign empty     = r_empty;
  assign lastLayer = r_lastLayer;
  assign lastPixel = r_lastPixel;
  assign busy      = (r_state != IDLE);
  assign frameDone = r_frameDone;

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler: a 4x2 instance and a 3x2 instance,
// both with 4 layers. Expected tokens are queued when a frame is started and
// checked by per-instance monitors every cycle the DUT shows valid.
module tb_layer_scheduler;

  localparam int VP = 2;

  typedef struct packed {
    logic [1:0] layer;
    logic [1:0] x;
    logic [0:0] y;
    logic       empty;
    logic       lastLayer;
    logic       lastPixel;
  } tok_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, start3 = 1'b0;
  logic [3:0] layerEn = 4'b0, layerEn3 = 4'b0;
  logic       ready = 1'b1, ready3 = 1'b1;

  logic       valid, empty, lastLayer, lastPixel, busy, frameDone;
  logic [1:0] layer, x;
  logic [0:0] y;
  logic       valid3, empty3, lastLayer3, lastPixel3, busy3, frameDone3;
  logic [1:0] layer3, x3;
  logic [0:0] y3;

  int   tests = 0;
  int   fails = 0;
  int   tok0  = 0;
  tok_t q0[$];
  tok_t q3[$];
  logic done_exp0 = 1'b0, done_exp3 = 1'b0;
  logic [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  layer_scheduler #(.HOR_PIX(4), .VER_PIX(VP), .NUM_LAYERS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .layerEn(layerEn), .ready(ready),
    .valid(valid), .layer(layer), .x(x), .y(y), .empty(empty),
    .lastLayer(lastLayer), .lastPixel(lastPixel), .busy(busy), .frameDone(frameDone)
  );

  layer_scheduler #(.HOR_PIX(3), .VER_PIX(VP), .NUM_LAYERS(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .layerEn(layerEn3), .ready(ready3),
    .valid(valid3), .layer(layer3), .x(x3), .y(y3), .empty(empty3),
    .lastLayer(lastLayer3), .lastPixel(lastPixel3), .busy(busy3), .frameDone(frameDone3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference raster walk: y outer, x middle, live layers inner.
  function automatic void push_frame(input int sel, input logic [3:0] m, input int hp);
    logic [3:0] eff;
    tok_t t;
    bit   above;
`ifdef LAYER_SCHED_SKIP_EN
    eff = m;
`else
    eff = 4'hF;
`endif
    for (int yy = 0; yy < VP; yy++) begin
      for (int xx = 0; xx < hp; xx++) begin
        for (int l = 0; l < 4; l++) begin
          if (eff[l] || (eff == 4'h0 && l == 0)) begin
            above = 1'b0;
            for (int k = l + 1; k < 4; k++) if (eff[k]) above = 1'b1;
            t.layer     = 2'(l);
            t.x         = 2'(xx);
            t.y         = 1'(yy);
            t.empty     = (eff == 4'h0);
            t.lastLayer = !above;
            t.lastPixel = !above && (xx == hp - 1) && (yy == VP - 1);
            if (sel == 0) q0.push_back(t);
            else          q3.push_back(t);
          end
        end
      end
    end
  endfunction

  // Monitor for the 4-wide instance.
  always @(negedge clk) begin
    if (!rst) begin
      done_exp0 = 1'b0;
    end else begin
      if (frameDone || done_exp0) check("frameDone0", frameDone, done_exp0);
      done_exp0 = 1'b0;
      if (valid) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL token0: got unexpected token l=%0d x=%0d y=%0d, expected none", layer, x, y);
        end else begin
          check("token0", {layer, x, y, empty, lastLayer, lastPixel}, q0[0]);
          if (ready) begin
            done_exp0 = q0[0].lastPixel;
            void'(q0.pop_front());
            tok0++;
          end
        end
      end
    end
  end

  // Monitor for the 3-wide instance.
  always @(negedge clk) begin
    if (!rst) begin
      done_exp3 = 1'b0;
    end else begin
      if (frameDone3 || done_exp3) check("frameDone3", frameDone3, done_exp3);
      done_exp3 = 1'b0;
      if (valid3) begin
        if (q3.size() == 0) begin
          tests++; fails++;
          $display("FAIL token3: got unexpected token l=%0d x=%0d y=%0d, expected none", layer3, x3, y3);
        end else begin
          check("token3", {layer3, x3, y3, empty3, lastLayer3, lastPixel3}, q3[0]);
          if (ready3) begin
            done_exp3 = q3[0].lastPixel;
            void'(q3.pop_front());
          end
        end
      end
    end
  end

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start = v; else start3 = v;
  endtask

  task automatic run_frame(input int sel, input logic [3:0] m, input bit toggle, input int hp);
    bit seen;
    seen = 1'b0;
    push_frame(sel, m, hp);
    @(posedge clk); #1;
    if (sel == 0) begin layerEn = m; ready = 1'b1; end
    else          begin layerEn3 = m; ready3 = 1'b1; end
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check("load_cycle", (sel == 0) ? {valid, busy} : {valid3, busy3}, 2'b01);
    @(posedge clk); #1;
    check("first_valid", (sel == 0) ? valid : valid3, 1'b1);
    // Mask changes after LOAD must not alter the running frame.
    if (sel == 0) layerEn = ~m; else layerEn3 = ~m;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (sel == 0) ready  = toggle ? pat[cyc % 4] : 1'b1;
      else          ready3 = toggle ? pat[cyc % 4] : 1'b1;
      @(posedge clk); #1;
      if ((sel == 0) ? frameDone : frameDone3) seen = 1'b1;
    end
    check("frameDone_seen", seen, 1'b1);
    check("done_cycle", (sel == 0) ? {valid, busy} : {valid3, busy3}, 2'b01);
    check("tokens_left", (sel == 0) ? q0.size() : q3.size(), 0);
    // start during DONE is ignored.
    set_start(sel, 1'b1);
    if (sel == 0) ready = 1'b1; else ready3 = 1'b1;
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check("idle_after_done", (sel == 0) ? {frameDone, busy} : {frameDone3, busy3}, 2'b00);
    @(posedge clk); #1;
    check("start_in_done_ignored", (sel == 0) ? busy : busy3, 1'b0);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {valid, busy, frameDone, layer, x, y, empty, lastLayer, lastPixel}, 0);
    check("reset_outputs3", {valid3, busy3, frameDone3, layer3, x3, y3, empty3, lastLayer3, lastPixel3}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {valid, busy}, 2'b00);

    run_frame(0, 4'b1111, 1'b0, 4);
    run_frame(0, 4'b1010, 1'b0, 4);
    run_frame(0, 4'b0000, 1'b0, 4);
    run_frame(0, 4'b0001, 1'b1, 4);

    // Asynchronous reset part-way through a frame.
    base = tok0;
    push_frame(0, 4'b1111, 4);
    @(posedge clk); #1;
    layerEn = 4'b1111; ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (tok0 - base >= 5) break;
    end
    check("reached_token5", (tok0 - base >= 5), 1'b1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {valid, busy, frameDone, layer, x, y, empty, lastLayer, lastPixel}, 0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    check("held_in_reset", {valid, busy, frameDone}, 3'b000);
    rst = 1'b1;
    @(posedge clk); #1;
    check("no_frameDone_after_reset", {frameDone, busy}, 2'b00);
    run_frame(0, 4'b1111, 1'b0, 4);

    // Non-power-of-two width.
    run_frame(1, 4'b1000, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
